// File: rtl/imm_encoder.sv
// LEGv8 immediate encoder: packs opcode, register fields and a signed immediate into an
// I-type or D-type word, range-checking the immediate. Optional clamping under IMM_ENC_SATURATE_EN.
module imm_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_is_d_type,
    input  logic [10:0]      in_opcode,
    input  logic [1:0]       in_op2,
    input  logic [4:0]       in_rn,
    input  logic [4:0]       in_rd,
    input  logic [63:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_is_d_type,
    output logic             out_err,
    input  logic             clear_counts,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    logic             out_valid_q;
    logic [31:0]      out_instr_q;
    logic             out_is_d_q;
    logic             out_err_q;
    logic [CNT_W-1:0] enc_count_q;
    logic [CNT_W-1:0] err_count_q;

    logic        accept;
    logic        fits_i;
    logic        fits_d;
    logic        err_d;
    logic [11:0] imm_i_field;
    logic [8:0]  imm_d_field;
    logic [31:0] word_i;
    logic [31:0] word_d;
    logic [31:0] instr_d;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // A value fits when every bit above the field's sign bit matches that sign bit.
    assign fits_i = (&in_imm[63:11]) || !(|in_imm[63:11]);
    assign fits_d = (&in_imm[63:8])  || !(|in_imm[63:8]);
    assign err_d  = in_is_d_type ? !fits_d : !fits_i;

`ifdef IMM_ENC_SATURATE_EN
    assign imm_i_field = fits_i ? in_imm[11:0] : (in_imm[63] ? 12'h800 : 12'h7FF);
    assign imm_d_field = fits_d ? in_imm[8:0]  : (in_imm[63] ? 9'h100  : 9'h0FF);
`else
    assign imm_i_field = in_imm[11:0];
    assign imm_d_field = in_imm[8:0];
`endif

    assign word_i = {in_opcode[9:0], imm_i_field, in_rn, in_rd};
    assign word_d = {in_opcode, imm_d_field, in_op2, in_rn, in_rd};

    always_comb begin
        instr_d = in_is_d_type ? word_d : word_i;
`ifndef IMM_ENC_SATURATE_EN
        if (err_d) begin
            instr_d = 32'h0;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_instr_q <= 32'h0;
            out_is_d_q  <= 1'b0;
            out_err_q   <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_instr_q <= instr_d;
            out_is_d_q  <= in_is_d_type;
            out_err_q   <= err_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Counters track acceptances; a simultaneous clear drops that request from the tally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enc_count_q <= '0;
            err_count_q <= '0;
        end else if (clear_counts) begin
            enc_count_q <= '0;
            err_count_q <= '0;
        end else if (accept) begin
            if (err_d) begin
                err_count_q <= err_count_q + CNT_W'(1);
            end else begin
                enc_count_q <= enc_count_q + CNT_W'(1);
            end
        end
    end

    assign out_valid     = out_valid_q;
    assign out_instr     = out_instr_q;
    assign out_is_d_type = out_is_d_q;
    assign out_err       = out_err_q;
    assign enc_count     = enc_count_q;
    assign err_count     = err_count_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: vector table streamed through a scoreboard queue,
// plus backpressure, counter-clear and reset-during-stall sequences.
module tb_imm_encoder;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic             in_is_d_type;
    logic [10:0]      in_opcode;
    logic [1:0]       in_op2;
    logic [4:0]       in_rn;
    logic [4:0]       in_rd;
    logic [63:0]      in_imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic             out_is_d_type;
    logic             out_err;
    logic             clear_counts;
    logic [CNT_W-1:0] enc_count;
    logic [CNT_W-1:0] err_count;

    imm_encoder #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_is_d_type(in_is_d_type), .in_opcode(in_opcode), .in_op2(in_op2),
        .in_rn(in_rn), .in_rd(in_rd), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_is_d_type(out_is_d_type), .out_err(out_err),
        .clear_counts(clear_counts), .enc_count(enc_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_d;
        logic [10:0] opcode;
        logic [1:0]  op2;
        logic [4:0]  rn;
        logic [4:0]  rd;
        logic [63:0] imm;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        logic        is_d;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_enc = 0;
    int   m_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model using signed arithmetic on the immediate.
    task automatic model(input vec_t v, output exp_t e);
        longint s, lo, hi, c;
        logic [63:0] cb;
        s  = $signed(v.imm);
        lo = v.is_d ? -256 : -2048;
        hi = v.is_d ? 255 : 2047;
        e.err  = (s < lo) || (s > hi);
        e.is_d = v.is_d;
        c = (s < lo) ? lo : ((s > hi) ? hi : s);
        cb = c;
        if (v.is_d) e.instr = {v.opcode, cb[8:0], v.op2, v.rn, v.rd};
        else        e.instr = {v.opcode[9:0], cb[11:0], v.rn, v.rd};
`ifndef IMM_ENC_SATURATE_EN
        if (e.err) e.instr = 32'h0;
`endif
    endtask

    task automatic drive(input logic valid, input vec_t v);
        in_valid     = valid;
        in_is_d_type = v.is_d;
        in_opcode    = v.opcode;
        in_op2       = v.op2;
        in_rn        = v.rn;
        in_rd        = v.rd;
        in_imm       = v.imm;
    endtask

    // One cycle: pop on output handshake, push on input handshake, then check counters.
    task automatic step(input exp_t e);
        exp_t got;
        #1;
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_output", {63'd0, out_valid}, 64'd0);
            end else begin
                got = sb_q.pop_front();
                chk("out_instr", {32'd0, out_instr}, {32'd0, got.instr});
                chk("out_err", {63'd0, out_err}, {63'd0, got.err});
                chk("out_is_d_type", {63'd0, out_is_d_type}, {63'd0, got.is_d});
                $display("txn out instr=%h err=%0d d=%0d", out_instr, out_err, out_is_d_type);
            end
        end
        if (clear_counts) begin
            m_enc = 0; m_err = 0;
        end else if (in_valid && in_ready) begin
            if (e.err) m_err++; else m_enc++;
        end
        if (in_valid && in_ready) sb_q.push_back(e);
        @(posedge clk);
        #1;
        chk("enc_count", {48'd0, enc_count}, 64'(m_enc % 65536));
        chk("err_count", {48'd0, err_count}, 64'(m_err % 65536));
        @(negedge clk);
    endtask

    vec_t tbl[13];
    vec_t v;
    exp_t e;
    exp_t hold_e;

    initial begin
        tbl[0]  = '{1'b0, 11'h244, 2'd0, 5'd3,  5'd5,  64'd100,              32'h91019065, 1'b0};
        tbl[1]  = '{1'b1, 11'h7C2, 2'd0, 5'd2,  5'd1,  -64'sd8,              32'hF85F8041, 1'b0};
        tbl[2]  = '{1'b0, 11'h244, 2'd0, 5'd0,  5'd0,  64'd2047,             32'h911FFC00, 1'b0};
        tbl[3]  = '{1'b0, 11'h244, 2'd0, 5'd0,  5'd0,  64'd2048,             32'h00000000, 1'b1};
        tbl[4]  = '{1'b1, 11'h7C2, 2'd0, 5'd0,  5'd0,  -64'sd256,            32'hF8500000, 1'b0};
        tbl[5]  = '{1'b1, 11'h7C2, 2'd0, 5'd0,  5'd0,  -64'sd257,            32'h00000000, 1'b1};
        tbl[6]  = '{1'b0, 11'h244, 2'd0, 5'd0,  5'd0,  -64'sd2048,           32'h91200000, 1'b0};
        tbl[7]  = '{1'b0, 11'h244, 2'd0, 5'd0,  5'd0,  -64'sd2049,           32'h00000000, 1'b1};
        tbl[8]  = '{1'b1, 11'h7C2, 2'd0, 5'd0,  5'd0,  64'd255,              32'hF84FF000, 1'b0};
        tbl[9]  = '{1'b1, 11'h7C2, 2'd0, 5'd0,  5'd0,  64'd256,              32'h00000000, 1'b1};
        tbl[10] = '{1'b1, 11'h7C0, 2'd3, 5'd31, 5'd31, 64'd0,                32'hF8000FFF, 1'b0};
        tbl[11] = '{1'b0, 11'h5A2, 2'd3, 5'd1,  5'd2,  -64'sd1,              32'h68BFFC22, 1'b0};
        tbl[12] = '{1'b0, 11'h244, 2'd0, 5'd0,  5'd0,  64'h8000000000000000, 32'h00000000, 1'b1};

        reset = 1'b1; out_ready = 1'b1; clear_counts = 1'b0;
        v = tbl[0];
        drive(1'b0, v);
        #12;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_instr", {32'd0, out_instr}, 64'd0);
        chk("rst_out_err", {63'd0, out_err}, 64'd0);
        chk("rst_counts", {32'd0, enc_count, err_count}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Streaming table at full throughput.
        for (int i = 0; i < 13; i++) begin
            v = tbl[i];
`ifdef IMM_ENC_SATURATE_EN
            model(v, e);
`else
            e = '{v.exp_instr, v.exp_err, v.is_d};
`endif
            drive(1'b1, v);
            step(e);
        end
        // Random vectors checked against the model.
        for (int i = 0; i < 20; i++) begin
            v.is_d   = 1'($urandom_range(0, 1));
            v.opcode = 11'($urandom);
            v.op2    = 2'($urandom);
            v.rn     = 5'($urandom);
            v.rd     = 5'($urandom);
            v.imm    = 64'($signed(32'($urandom_range(0, 8191)) - 32'sd4096));
            model(v, e);
            drive(1'b1, v);
            step(e);
        end
        drive(1'b0, v);
        step(e);
        chk("drain_out_valid", {63'd0, out_valid}, 64'd0);

        // Backpressure: A accepted, B held off until out_ready rises.
        out_ready = 1'b0;
        v = tbl[0]; model(v, hold_e); drive(1'b1, v); step(hold_e);
        v = tbl[8]; model(v, e); drive(1'b1, v);
        #1;
        chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        step(e);
        chk("bp_hold_instr", {32'd0, out_instr}, {32'd0, hold_e.instr});
        chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
        step(e);
        chk("bp_hold_instr2", {32'd0, out_instr}, {32'd0, hold_e.instr});
        out_ready = 1'b1;
        step(e);
        drive(1'b0, v);
        step(e);
        step(e);
        chk("bp_queue_empty", 64'(sb_q.size()), 64'd0);

        // Clear coinciding with an accepted request.
        clear_counts = 1'b1;
        v = tbl[3]; model(v, e); drive(1'b1, v); step(e);
        clear_counts = 1'b0;
        drive(1'b0, v);
        step(e);
        chk("clear_enc", {48'd0, enc_count}, 64'd0);
        chk("clear_err", {48'd0, err_count}, 64'd0);

        // Reset while stalled.
        out_ready = 1'b0;
        v = tbl[1]; model(v, e); drive(1'b1, v); step(e);
        drive(1'b0, v);
        chk("stall_valid", {63'd0, out_valid}, 64'd1);
        chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
        reset = 1'b1;
        #1;
        chk("rst_stall_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_stall_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_stall_counts", {32'd0, enc_count, err_count}, 64'd0);
        sb_q.delete();
        m_enc = 0; m_err = 0;
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        v = tbl[2]; model(v, e); drive(1'b1, v); step(e);
        drive(1'b0, v);
        step(e);
        chk("final_queue_empty", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
